// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI target endpoint on the 11-bit command/data bus.
// External SCK/SS/MOSI are oversampled in the clk domain and MISO is driven
// back from a byte shift register. TX bytes arrive through a write FIFO and
// received bytes are popped from a read FIFO by the bus.
// Optional build macro: SPI_SLAVE_STATUS_EN adds sticky RX-overrun /
// TX-underrun flags on status; without it status is tied to 2'b00.
//
// state  | meaning
// IDLE   | SS deasserted (or not yet seen falling), MISO held high, OE low
// ACTIVE | SS asserted, bytes shifted in/out on SCK edges
module spi_slave_if #(
  parameter int unsigned SYNC_STAGES = 2,      // >= 2
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
  parameter int unsigned FIFO_DEPTH  = 4       // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] din,
  input  logic        cmd,
  input  logic        wr,
  input  logic        rd,
  output logic [8:0]  dout,
  output logic        ack,
  output logic [1:0]  status,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // settings
  logic [1:0] mode_q;
  logic       endian_q;
  logic       cpol, cpha;

  // synchronizers and edge strobes
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic sck_dly_q, ss_dly_q;
  logic sck_rise, sck_fall, lead_w, trail_w, ss_fall_w, ss_rise_w;
  logic lead_q, trail_q, ss_fall_q, ss_rise_q, mosi_smp_q;
  logic shift_evt, sample_evt;

  // FSM / datapath
  state_t     state_q, state_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       miso_q, miso_d;
  logic       reload_q, reload_d;
  logic       first_q, first_d;
  logic       tx_pop, rx_push, underrun_evt, overrun_evt;
  logic [7:0] tx_fill, tx_fill_ord, rx_next, rx_ord;

  // FIFOs
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, rx_pop;

  // bus side
  logic [8:0] dout_q, dout_d;
  logic       ack_q, ack_d;

  assign cpol = mode_q[1];
  assign cpha = mode_q[0];

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_push  = wr & ~tx_full;
  assign rx_pop   = rd & ~rx_empty;

  // Synchronize SCK/SS/MOSI; SS chain resets low so an SS level already low
  // at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      ss_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_dly_q   <= sck_sync_q[LAST];
      ss_dly_q    <= ss_sync_q[LAST];
    end
  end

  assign sck_rise  =  sck_sync_q[LAST] & ~sck_dly_q;
  assign sck_fall  = ~sck_sync_q[LAST] &  sck_dly_q;
  assign lead_w    = cpol ? sck_fall : sck_rise;
  assign trail_w   = cpol ? sck_rise : sck_fall;
  assign ss_fall_w = ~ss_sync_q[LAST] &  ss_dly_q;
  assign ss_rise_w =  ss_sync_q[LAST] & ~ss_dly_q;

  // Register the edge strobes with MOSI kept aligned to them
  always_ff @(posedge clk) begin
    if (rst) begin
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      ss_fall_q  <= 1'b0;
      ss_rise_q  <= 1'b0;
      mosi_smp_q <= 1'b0;
    end else begin
      lead_q     <= lead_w;
      trail_q    <= trail_w;
      ss_fall_q  <= ss_fall_w;
      ss_rise_q  <= ss_rise_w;
      mosi_smp_q <= mosi_sync_q[LAST];
    end
  end

  assign shift_evt  = cpha ? lead_q  : trail_q;
  assign sample_evt = cpha ? trail_q : lead_q;

  // Shift register always presents bit0 first; MSB-first bytes are reversed
  assign tx_fill     = tx_empty ? IDLE_BYTE : tx_mem_q[tx_rd_ptr_q];
  assign tx_fill_ord = endian_q ? tx_fill : bit_rev(tx_fill);
  assign rx_next     = {mosi_smp_q, rx_sh_q[7:1]};
  assign rx_ord      = endian_q ? rx_next : bit_rev(rx_next);

  // FSM state and shift datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b1;
      reload_q  <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      reload_q  <= reload_d;
      first_q   <= first_d;
    end
  end

  // Next-state, byte load, sampling and shifting
  always_comb begin
    state_d      = state_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    bit_cnt_d    = bit_cnt_q;
    miso_d       = miso_q;
    reload_d     = reload_q;
    first_d      = first_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    underrun_evt = 1'b0;
    overrun_evt  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b1;
        bit_cnt_d = '0;
        if (ss_fall_q) begin
          state_d      = ST_ACTIVE;
          tx_sh_d      = tx_fill_ord;
          miso_d       = tx_fill_ord[0];
          tx_pop       = ~tx_empty;
          underrun_evt = tx_empty;
          rx_sh_d      = '0;
          reload_d     = 1'b0;
          // CPHA=1: the first leading edge only presents bit0
          first_d      = cpha;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_q) begin
          state_d   = ST_IDLE;
          miso_d    = 1'b1;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          first_d   = 1'b0;
        end else begin
          if (sample_evt) begin
            rx_sh_d = rx_next;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = '0;
              reload_d    = 1'b1;
              rx_push     = ~rx_full;
              overrun_evt = rx_full;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          if (shift_evt) begin
            first_d = 1'b0;
            if (reload_q) begin
              tx_sh_d      = tx_fill_ord;
              miso_d       = tx_fill_ord[0];
              tx_pop       = ~tx_empty;
              underrun_evt = tx_empty;
              reload_d     = 1'b0;
            end else if (!first_q) begin
              tx_sh_d = {1'b1, tx_sh_q[7:1]};
              miso_d  = tx_sh_q[1];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_ACTIVE);

  // FIFO storage (no reset needed, validity tracked by pointers/counts)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= din[7:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_ord;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Bus read data and acknowledge for the next cycle
  always_comb begin
    dout_d = 9'h100;
    if (rx_pop) dout_d = {1'b0, rx_mem_q[rx_rd_ptr_q]};
    ack_d = tx_push | rd | cmd;
  end

  // Settings and bus response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 2'b00;
      endian_q <= 1'b0;
      dout_q   <= 9'h100;
      ack_q    <= 1'b0;
    end else begin
      if (cmd) begin
        mode_q   <= din[1:0];
        endian_q <= din[2];
      end
      dout_q <= dout_d;
      ack_q  <= ack_d;
    end
  end

  assign dout = dout_q;
  assign ack  = ack_q;

`ifdef SPI_SLAVE_STATUS_EN
  logic ovr_q, und_q;
  logic unused_bits;

  // Sticky flags; a new event wins over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      if (overrun_evt)       ovr_q <= 1'b1;
      else if (cmd & din[3]) ovr_q <= 1'b0;
      if (underrun_evt)      und_q <= 1'b1;
      else if (cmd & din[3]) und_q <= 1'b0;
    end
  end

  assign status      = {und_q, ovr_q};
  assign unused_bits = ^{din[10:8], tx_sh_q[0], rx_sh_q[0]};
`else
  logic unused_bits;

  assign status      = 2'b00;
  assign unused_bits = ^{din[10:8], din[3], overrun_evt, underrun_evt,
                         tx_sh_q[0], rx_sh_q[0]};
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
`timescale 1ns/1ps
module tb_spi_slave_if;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] din = '0;
  logic        cmd = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [8:0]  dout;
  logic        ack;
  logic [1:0]  status;
  logic        spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;

  int tests_run = 0;
  int tests_failed = 0;
  logic m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;

  spi_slave_if #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .din(din), .cmd(cmd), .wr(wr), .rd(rd),
    .dout(dout), .ack(ack), .status(status),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_cmd(input logic [3:0] v, output logic a);
    @(negedge clk); din = {7'd0, v}; cmd = 1'b1;
    @(negedge clk); cmd = 1'b0; a = ack;
    m_cpol = v[1]; m_cpha = v[0]; m_lsb = v[2];
    spi_sck = v[1];
    cycles(6);
  endtask

  task automatic bus_wr(input logic [7:0] b, output logic a, output logic a_next);
    @(negedge clk); din = {3'd0, b}; wr = 1'b1;
    @(negedge clk); wr = 1'b0; a = ack;
    @(negedge clk); a_next = ack;
  endtask

  task automatic bus_rd(output logic [8:0] d, output logic a);
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0; d = dout; a = ack;
  endtask

  // Master model: first byte in tx[7:0]; MISO bits collected in time order
  task automatic spi_xfer(input logic [15:0] tx, input int nbits, input bit keep_ss,
                          output logic [15:0] seq, output logic oe_mid);
    seq = '0; oe_mid = 1'b0;
    spi_sck = m_cpol; spi_ss = 1'b0;
    cycles(HALF);
    for (int i = 0; i < nbits; i++) begin
      int k;
      k = (i / 8) * 8 + (m_lsb ? (i % 8) : (7 - (i % 8)));
      if (!m_cpha) begin
        spi_mosi = tx[k];
        cycles(HALF);
        spi_sck = ~m_cpol;
        seq = {seq[14:0], spi_miso};
        if (i == 0) oe_mid = spi_miso_oe;
        cycles(HALF);
        spi_sck = m_cpol;
      end else begin
        spi_sck = ~m_cpol;
        spi_mosi = tx[k];
        cycles(HALF);
        spi_sck = m_cpol;
        seq = {seq[14:0], spi_miso};
        if (i == 0) oe_mid = spi_miso_oe;
        cycles(HALF);
      end
    end
    if (!keep_ss) begin
      cycles(HALF);
      spi_ss = 1'b1;
      cycles(12);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cycles(4); rst = 1'b0; cycles(4);
    tests_run++; if (dout !== 9'h100) begin tests_failed++; $display("FAIL reset_dout: got %h exp 100", dout); end
    tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b exp 0", ack); end
    tests_run++; if (spi_miso !== 1'b1) begin tests_failed++; $display("FAIL reset_miso: got %b exp 1", spi_miso); end
    tests_run++; if (spi_miso_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b exp 0", spi_miso_oe); end
    tests_run++; if (status !== 2'b00) begin tests_failed++; $display("FAIL reset_status: got %b exp 00", status); end
  endtask

  task automatic test_mode0();
    logic a, a2, oe; logic [15:0] seq; logic [8:0] d;
    bus_cmd(4'b0000, a);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL m0_cmd_ack: got %b exp 1", a); end
    bus_wr(8'hA5, a, a2);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL m0_wr_ack: got %b exp 1", a); end
    tests_run++; if (a2 !== 1'b0) begin tests_failed++; $display("FAIL m0_wr_ack_pulse: got %b exp 0", a2); end
    spi_xfer(16'h003C, 8, 1'b0, seq, oe);
    tests_run++; if (seq[7:0] !== 8'hA5) begin tests_failed++; $display("FAIL m0_miso: got %h exp a5", seq[7:0]); end
    tests_run++; if (oe !== 1'b1) begin tests_failed++; $display("FAIL m0_oe_active: got %b exp 1", oe); end
    tests_run++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin tests_failed++; $display("FAIL m0_idle_after: got oe=%b miso=%b exp oe=0 miso=1", spi_miso_oe, spi_miso); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h03C) begin tests_failed++; $display("FAIL m0_rd: got %h exp 03c", d); end
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL m0_rd_ack: got %b exp 1", a); end
    @(negedge clk);
    tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL m0_rd_ack_pulse: got %b exp 0", ack); end
  endtask

  task automatic test_mode3_lsb();
    logic a, a2, oe; logic [15:0] seq; logic [8:0] d;
    bus_cmd(4'b0111, a);
    bus_wr(8'h81, a, a2);
    spi_xfer(16'h0001, 8, 1'b0, seq, oe);
    tests_run++; if (seq[7:0] !== 8'h81) begin tests_failed++; $display("FAIL m3_miso: got %h exp 81", seq[7:0]); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h001) begin tests_failed++; $display("FAIL m3_rd: got %h exp 001", d); end
  endtask

  task automatic test_mode1_msb();
    logic a, a2, oe; logic [15:0] seq; logic [8:0] d;
    bus_cmd(4'b0001, a);
    bus_wr(8'h12, a, a2);
    spi_xfer(16'h00C4, 8, 1'b0, seq, oe);
    tests_run++; if (seq[7:0] !== 8'h12) begin tests_failed++; $display("FAIL m1_miso: got %h exp 12", seq[7:0]); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h0C4) begin tests_failed++; $display("FAIL m1_rd: got %h exp 0c4", d); end
  endtask

  task automatic test_back_to_back();
    logic a, a2, oe; logic [15:0] seq; logic [8:0] d;
    bus_cmd(4'b0000, a);
    bus_wr(8'h12, a, a2);
    bus_wr(8'h34, a, a2);
    spi_xfer(16'h5AC4, 16, 1'b0, seq, oe);
    tests_run++; if (seq !== 16'h1234) begin tests_failed++; $display("FAIL b2b_miso: got %h exp 1234", seq); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h0C4) begin tests_failed++; $display("FAIL b2b_rd0: got %h exp 0c4", d); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h05A) begin tests_failed++; $display("FAIL b2b_rd1: got %h exp 05a", d); end
  endtask

  task automatic test_underrun();
    logic a, oe; logic [15:0] seq; logic [8:0] d; logic [1:0] exp_st;
    bus_cmd(4'b1000, a);
    tests_run++; if (status !== 2'b00) begin tests_failed++; $display("FAIL und_cleared: got %b exp 00", status); end
    spi_xfer(16'h0000, 8, 1'b0, seq, oe);
    tests_run++; if (seq[7:0] !== 8'hFF) begin tests_failed++; $display("FAIL und_idle_byte: got %h exp ff", seq[7:0]); end
`ifdef SPI_SLAVE_STATUS_EN
    exp_st = 2'b10;
`else
    exp_st = 2'b00;
`endif
    tests_run++; if (status !== exp_st) begin tests_failed++; $display("FAIL und_flag: got %b exp %b", status, exp_st); end
    bus_cmd(4'b1000, a);
    tests_run++; if (status !== 2'b00) begin tests_failed++; $display("FAIL und_clear: got %b exp 00", status); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h000) begin tests_failed++; $display("FAIL und_rd: got %h exp 000", d); end
  endtask

  task automatic test_overrun();
    logic a, oe; logic [15:0] seq; logic [8:0] d; logic exp_ovr;
    bus_cmd(4'b1000, a);
    for (int i = 1; i <= 4; i++) spi_xfer({8'h00, 4'(i), 4'(i)}, 8, 1'b0, seq, oe);
    tests_run++; if (status[0] !== 1'b0) begin tests_failed++; $display("FAIL ovr_not_yet: got %b exp 0", status[0]); end
    spi_xfer(16'h0055, 8, 1'b0, seq, oe);
`ifdef SPI_SLAVE_STATUS_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    tests_run++; if (status[0] !== exp_ovr) begin tests_failed++; $display("FAIL ovr_flag: got %b exp %b", status[0], exp_ovr); end
    for (int i = 1; i <= 4; i++) begin
      bus_rd(d, a);
      tests_run++; if (d !== {1'b0, 4'(i), 4'(i)}) begin tests_failed++; $display("FAIL ovr_rd%0d: got %h exp %h", i, d, {1'b0, 4'(i), 4'(i)}); end
    end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h100) begin tests_failed++; $display("FAIL ovr_rd_empty: got %h exp 100", d); end
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL ovr_rd_empty_ack: got %b exp 1", a); end
  endtask

  task automatic test_partial();
    logic a, oe; logic [15:0] seq; logic [8:0] d;
    spi_xfer(16'h00F0, 5, 1'b0, seq, oe);
    spi_xfer(16'h0055, 8, 1'b0, seq, oe);
    bus_rd(d, a);
    tests_run++; if (d !== 9'h055) begin tests_failed++; $display("FAIL part_rd: got %h exp 055", d); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h100) begin tests_failed++; $display("FAIL part_rd_empty: got %h exp 100", d); end
  endtask

  task automatic test_reset_mid();
    logic a, a2, oe; logic [15:0] seq; logic [8:0] d;
    for (int i = 1; i <= 4; i++) bus_wr(8'(i), a, a2);
    bus_wr(8'h05, a, a2);
    tests_run++; if (a !== 1'b0) begin tests_failed++; $display("FAIL full_wr_ack: got %b exp 0", a); end
    spi_xfer(16'h00FF, 3, 1'b1, seq, oe);
    tests_run++; if (spi_miso_oe !== 1'b1) begin tests_failed++; $display("FAIL mid_oe_before: got %b exp 1", spi_miso_oe); end
    rst = 1'b1; cycles(3);
    tests_run++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_pins: got oe=%b miso=%b exp oe=0 miso=1", spi_miso_oe, spi_miso); end
    rst = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    spi_sck = 1'b1; cycles(HALF); spi_sck = 1'b0; cycles(HALF);
    tests_run++; if (spi_miso_oe !== 1'b0) begin tests_failed++; $display("FAIL mid_ss_level_ignored: got %b exp 0", spi_miso_oe); end
    spi_ss = 1'b1; cycles(12);
    bus_rd(d, a);
    tests_run++; if (d !== 9'h100) begin tests_failed++; $display("FAIL mid_rx_empty: got %h exp 100", d); end
    spi_xfer(16'h003A, 8, 1'b0, seq, oe);
    tests_run++; if (seq[7:0] !== 8'hFF) begin tests_failed++; $display("FAIL mid_tx_empty: got %h exp ff", seq[7:0]); end
    bus_rd(d, a);
    tests_run++; if (d !== 9'h03A) begin tests_failed++; $display("FAIL mid_clean_frame: got %h exp 03a", d); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_mode1_msb();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave (target) endpoint for the same 11-bit command/data bus our SPI master uses.
- Oversamples external SCK/SS/MOSI in the clk domain and drives MISO.
- Bytes to transmit go through a write FIFO; received bytes go into a read FIFO popped by the bus.
- Mode (CPOL/CPHA) and bit order are set by a command write. Lets one of our devices act as the peripheral on an external SPI link.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at byte start.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- din  in  11  bus data; [7:0] TX byte on wr; [1:0] mode, [2] endianness on cmd
- cmd  in  1  write settings
- wr  in  1  push TX byte
- rd  in  1  pop RX byte
- dout  out  9  {1'b0, byte} when valid, else {1'b1, 8'h00}
- ack  out  1  registered acknowledge
- status  out  2  [0] RX overrun, [1] TX underrun (optional feature)
- spi_sck  in  1  external SCK
- spi_ss  in  1  external slave select, active low
- spi_mosi  in  1  external MOSI
- spi_miso  out  1  MISO data
- spi_miso_oe  out  1  MISO output enable, high only while SS is asserted

Behaviour:
- Reset and clocking: reset rst, synchronous, active-high; clock clk.
- Reset values: mode=00, endianness=0 (MSB first), FIFOs empty, bit_cnt=0, spi_miso=1, spi_miso_oe=0, ack=0, dout={1'b1,8'h00}, status=00.
- Clock ratio: clk ≥ 8× SCK. Each SCK phase lasts ≥ 3 clk periods.
- Input synchronizers: SCK, SS and MOSI each pass through SYNC_STAGES flip-flops. Edges are detected on the last stage against one extra delayed copy.
- Edge mapping: leading edge = rise if CPOL=0, fall if CPOL=1; trailing edge is the other one.
- Settings: cmd loads mode and endianness in 1 cycle. Changing settings while SS is low is undefined; the bench must not do it.
- FSM states IDLE, ACTIVE:
  - IDLE→ACTIVE on synchronized SS falling edge.
  - ACTIVE→IDLE on SS rising edge, from any bit position. A partial byte is discarded and bit_cnt is cleared.
- Byte load, at SS fall and at each byte boundary while SS stays low:
  - Pop the TX FIFO into the shift register, bit-reversed if endianness=0, same ordering rule as the master.
  - If the FIFO is empty, load IDLE_BYTE and set the underrun flag.
- CPHA=0:
  - MISO presents bit0 of the shift register immediately on load.
  - Sample MOSI on the leading edge; shift on the trailing edge.
- CPHA=1:
  - Shift out on the leading edge; sample on the trailing edge.
  - The first leading edge after load presents bit0 without shifting.
- Byte completion:
  - bit_cnt counts samples 0..7.
  - On the 8th sample, push the ordered byte to the RX FIFO in the same cycle.
  - If the RX FIFO is full, drop the byte and set the overrun flag.
  - Reload TX for the next byte on the next shift event.
- MISO timing: spi_miso updates 1 cycle after the detected edge. Total input-to-output delay is SYNC_STAGES+2 clk cycles.
- spi_miso_oe = ACTIVE state registered; spi_miso = 1 while in IDLE.
- wr behaviour: push when the TX FIFO is not full; dropped silently when full. wr is acked only if pushed.
- rd behaviour: dout is valid 1 cycle after rd when the RX FIFO is not empty, else {1'b1,8'h00}. rd is always acked.
- ack = registered (accepted wr | rd | cmd), 1-cycle latency.
- Simultaneous wr and TX pop: both occur and the FIFO count is unchanged. The same applies to RX push and rd pop.
- Reset mid-transfer: everything returns to reset values. The SS low level already present is ignored until a new falling edge.

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- Defined:
  - status[0]/[1] are sticky overrun/underrun flags.
  - They are cleared by cmd when din[3]=1; set has priority over clear in the same cycle.
- Undefined: status tied to 2'b00 and the flag logic is absent.

Test Plan:
- Mode 0, MSB first: wr 8'hA5, master sends 8'h3C → MISO bits 1,0,1,0,0,1,0,1; rd returns 9'h03C; ack pulses once per access.
- Mode 3, LSB first (cmd din=3'b111), TX 8'h81, RX 8'h01 → MISO LSB-first 1,0,0,0,0,0,0,1 sampled on rising edges; dout 9'h001.
- TX FIFO empty at SS fall → MISO shifts 8'hFF; status[1]=1 with macro; cmd din[3]=1 clears it.
- RX FIFO full + 1 more byte → byte dropped, status[0]=1, FIFO contents unchanged; rd on empty FIFO → 9'h100.
- SS rises after 5 bits, then a full 8'h55 frame → only 8'h55 is in the RX FIFO; bit_cnt restarted at 0.
- Mid-frame rst → spi_miso_oe=0, spi_miso=1, FIFOs empty, next SS fall starts a clean frame.
